// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller: phase states, lamp encodings
// and per-road lamp decode.
package traffic_pkg;

    typedef enum logic [2:0] {
        INIT,
        NS_G,
        NS_Y,
        RED_A,
        EW_G,
        EW_Y,
        RED_B,
        WALK
    } state_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    function automatic logic [2:0] ns_lamp(input state_e s);
        case (s)
            NS_G:    return LAMP_G;
            NS_Y:    return LAMP_Y;
            default: return LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_e s);
        case (s)
            EW_G:    return LAMP_G;
            EW_Y:    return LAMP_Y;
            default: return LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/ped_req_latch.sv
// Pedestrian request holding flop: set by a button press, cleared when the
// WALK phase is entered. Clear wins over a same-cycle set.
module ped_req_latch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_pending
);

    logic r_pending;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
        end else if (i_clr) begin
            r_pending <= 1'b0;
        end else if (i_set) begin
            r_pending <= 1'b1;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/traffic_timer.sv
// Shared countdown timer placed beside the controller: loads on request,
// otherwise counts down and wraps; resets to all-ones.
module traffic_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_zero,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '1;
        end else if (i_load) begin
            r_count <= i_data;
        end else begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero  = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light sequencer with optional pedestrian WALK phase; drives
// an external countdown timer and advances on its zero flag.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH = 16,
    parameter int unsigned GREEN_T     = 50000,
    parameter int unsigned YELLOW_T    = 10000,
    parameter int unsigned ALL_RED_T   = 2000,
    parameter int unsigned WALK_T      = 30000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   tmr_zero_i,
    output logic                   tmr_load_o,
    output logic [TIMER_WIDTH-1:0] tmr_data_o,
    input  logic                   ped_req_i,
    output logic                   ped_ack_o,
    output logic [2:0]             ns_o,
    output logic [2:0]             ew_o,
    output logic                   walk_o
);

    localparam longint unsigned MAX_T = longint'(1) << TIMER_WIDTH;
    localparam bit LENS_OK =
        (GREEN_T   >= 1) && (longint'(GREEN_T)   <= MAX_T) &&
        (YELLOW_T  >= 1) && (longint'(YELLOW_T)  <= MAX_T) &&
        (ALL_RED_T >= 1) && (longint'(ALL_RED_T) <= MAX_T) &&
        (WALK_T    >= 1) && (longint'(WALK_T)    <= MAX_T);

    if (!LENS_OK) begin : g_len_check
        $error("traffic_light_ctrl: phase length outside 1..2**TIMER_WIDTH");
    end

    state_e      r_state;
    state_e      w_next;
    logic        w_load;
    logic        w_pending;
    logic        w_enter_walk;
    int unsigned w_len;
    logic [2:0]  r_ns;
    logic [2:0]  r_ew;
    logic        r_walk;
    logic        r_ack;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // A phase ends on the timer's zero cycle; the same cycle reloads the timer
    // with the next phase's length so every phase lasts exactly its parameter.
    always_comb begin
        w_load       = (r_state == INIT) || tmr_zero_i;
        w_next       = r_state;
        w_enter_walk = 1'b0;
        w_len        = ALL_RED_T;
        if (w_load) begin
            case (r_state)
                INIT:    w_next = RED_A;
                RED_A:   w_next = EW_G;
                EW_G:    w_next = EW_Y;
                EW_Y:    w_next = RED_B;
                RED_B:   w_next = w_pending ? WALK : NS_G;
                WALK:    w_next = NS_G;
                NS_G:    w_next = NS_Y;
                NS_Y:    w_next = RED_A;
                default: w_next = INIT;
            endcase
            w_enter_walk = (r_state == RED_B) && w_pending;
        end
        case (w_next)
            NS_G, EW_G: w_len = GREEN_T;
            NS_Y, EW_Y: w_len = YELLOW_T;
            WALK:       w_len = WALK_T;
            default:    w_len = ALL_RED_T;
        endcase
    end

    assign tmr_load_o = w_load;
    assign tmr_data_o = TIMER_WIDTH'(w_len - 32'd1);

    ped_req_latch u_ped_latch (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_set     (ped_req_i && (r_state != WALK)),
        .i_clr     (w_enter_walk),
        .o_pending (w_pending)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ns   <= LAMP_R;
            r_ew   <= LAMP_R;
            r_walk <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_ns   <= ns_lamp(w_next);
            r_ew   <= ew_lamp(w_next);
            r_walk <= (w_next == WALK);
            r_ack  <= w_enter_walk;
        end
    end

    assign ns_o      = r_ns;
    assign ew_o      = r_ew;
    assign walk_o    = r_walk;
    assign ped_ack_o = r_ack;

endmodule
